// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory stage of the RV32IM five-stage pipeline. Takes the execute stage's
// M-stage outputs, runs the data-memory request/ready handshake, builds store
// byte enables and lane-replicated store data, aligns and extends load data,
// flags misaligned accesses, and owns the MEM/WB pipeline register. While a
// memory access is waiting on the memory, StallM freezes the upstream stages.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   RegWriteM, MemWriteM     register write enable / store flag from execute
//   ResultSrcM[2:0]          writeback select (3'b001 = load)
//   LoadControlM[2:0]        LB/LH/LW/LBU/LHU select
//   StoreControlM[2:0]       SB/SH/SW select
//   rdM[4:0]                 destination register
//   ALUResultM[31:0]         effective address / ALU result
//   WriteDataM[31:0]         right-justified store data
//   PCPlus4M, PCTargetM      passed through to writeback
//   DMemRData[31:0]          memory read word
//   DMemReady                memory completes the current request this cycle
//   DMemReq, DMemWe          request strobe and write flag
//   DMemAddr[31:0]           word-aligned access address
//   DMemWData[31:0]          lane-replicated store data
//   DMemBE[3:0]              store byte enables (zero on reads)
//   StallM                   freeze F/D/E/M this cycle
//   MisalignM                misaligned access detected this cycle
//   RegWriteW ... PCTargetW  MEM/WB register outputs
// -----------------------------------------------------------------------------
module mem_access_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [2:0]  ResultSrcM,
  input  logic [2:0]  LoadControlM,
  input  logic [2:0]  StoreControlM,
  input  logic [4:0]  rdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] PCTargetM,
  input  logic [31:0] DMemRData,
  input  logic        DMemReady,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic [3:0]  DMemBE,
  output logic        StallM,
  output logic        MisalignM,
  output logic        RegWriteW,
  output logic [2:0]  ResultSrcW,
  output logic [4:0]  rdW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] PCTargetW
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [1:0]  offset;
  logic [1:0]  size;        // 00 byte, 01 half, 10 word
  logic        is_load;
  logic        mem_op;
  logic        misalign;
  logic [31:0] store_data;
  logic [3:0]  store_be;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  // ---------------------------------------------------------------------------
  // Access decode and misalignment
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    offset   = ALUResultM[1:0];
    is_load  = (ResultSrcM == 3'b001);
    mem_op   = is_load || MemWriteM;
    size     = MemWriteM ? StoreControlM[1:0] : LoadControlM[1:0];
    misalign = mem_op && (((size == 2'b01) && offset[0]) ||
                          ((size == 2'b10) && (offset != 2'b00)));
  end

  assign MisalignM = !RST && misalign;
  assign DMemAddr  = {ALUResultM[31:2], 2'b00};

  // ---------------------------------------------------------------------------
  // Store lane replication and byte enables
  // ---------------------------------------------------------------------------
  always_comb begin
    store_data = WriteDataM;
    store_be   = 4'b1111;
    case (StoreControlM)
      3'b000: begin
        store_data = {4{WriteDataM[7:0]}};
        store_be   = 4'b0001 << offset;
      end
      3'b001: begin
        store_data = {2{WriteDataM[15:0]}};
        store_be   = 4'b0011 << offset;
      end
      default: begin
        store_data = WriteDataM;
        store_be   = 4'b1111;
      end
    endcase
  end

  assign DMemWData = store_data;

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  assign shifted = DMemRData >> {offset, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (LoadControlM)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h000000, shifted[7:0]};
      3'b101:  load_ext = {16'h0000, shifted[15:0]};
      default: load_ext = DMemRData;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    DMemReq = 1'b0;
    StallM  = 1'b0;
    if (!RST) begin
      case (state_q)
        S_IDLE: begin
          if (mem_op && !misalign) begin
            DMemReq = 1'b1;
            if (!DMemReady) begin
              StallM  = 1'b1;
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Upstream is frozen, so the M inputs still describe this access.
          DMemReq = 1'b1;
          if (DMemReady) state_d = S_IDLE;
          else           StallM  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign DMemWe = DMemReq && MemWriteM;
  assign DMemBE = DMemWe ? store_be : 4'b0000;

  // ---------------------------------------------------------------------------
  // MEM/WB pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 3'b000;
      rdW        <= 5'd0;
      ALUResultW <= 32'h0;
      ReadDataW  <= 32'h0;
      PCPlus4W   <= 32'h0;
      PCTargetW  <= 32'h0;
    end else if (StallM) begin
      // Bubble: kill the write, keep the data fields as they were.
      RegWriteW <= 1'b0;
      rdW       <= 5'd0;
    end else begin
      // A misaligned access is retired without a register write.
      RegWriteW  <= RegWriteM && !misalign;
      ResultSrcW <= ResultSrcM;
      rdW        <= rdM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= (is_load && !misalign) ? load_ext : 32'h0;
      PCPlus4W   <= PCPlus4M;
      PCTargetW  <= PCTargetM;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. Each scenario task drives M-stage
// stimulus; expected MEM/WB contents are pushed to a scoreboard queue when an
// operation is driven and popped/compared once the completing edge has passed.
// Inputs change 1 ns after posedge; combinational outputs are sampled at
// negedge, registered outputs 1 ns after posedge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RegWriteM, MemWriteM;
  logic [2:0]  ResultSrcM, LoadControlM, StoreControlM;
  logic [4:0]  rdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetM, DMemRData;
  logic        DMemReady;
  logic        DMemReq, DMemWe, StallM, MisalignM;
  logic [31:0] DMemAddr, DMemWData;
  logic [3:0]  DMemBE;
  logic        RegWriteW;
  logic [2:0]  ResultSrcW;
  logic [4:0]  rdW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, PCTargetW;

  mem_access_unit dut (
    .CLK(CLK), .RST(RST),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .LoadControlM(LoadControlM), .StoreControlM(StoreControlM), .rdM(rdM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .PCTargetM(PCTargetM),
    .DMemRData(DMemRData), .DMemReady(DMemReady),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemWData(DMemWData), .DMemBE(DMemBE),
    .StallM(StallM), .MisalignM(MisalignM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .rdW(rdW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W), .PCTargetW(PCTargetW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rw;
    logic [2:0]  rsrc;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [31:0] pct;
  } w_t;

  w_t          sb[$];
  w_t          last_w;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc = 32'h0000_1000;

  localparam logic [2:0] RS_ALU  = 3'b000;
  localparam logic [2:0] RS_LOAD = 3'b001;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  task automatic drive_nop();
    RegWriteM     = 1'b0;
    MemWriteM     = 1'b0;
    ResultSrcM    = RS_ALU;
    LoadControlM  = LW;
    StoreControlM = SW;
    rdM           = 5'd0;
    ALUResultM    = 32'h0;
    WriteDataM    = 32'h0;
    PCPlus4M      = 32'h0;
    PCTargetM     = 32'h0;
    DMemRData     = 32'h0;
    DMemReady     = 1'b0;
  endtask

  // Drives one M-stage operation for waits+1 cycles (ready in the last one),
  // checking the handshake every cycle and the W register after completion.
  task automatic run_op(input string name, input logic rw, input logic mw,
                        input logic [2:0] rsrc, input logic [2:0] lc,
                        input logic [2:0] sc, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] rdata, input int waits,
                        input logic [31:0] exp_rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata);
    w_t   e;
    logic is_mem;
    is_mem  = mw || (rsrc == RS_LOAD);
    e.rw    = rw;
    e.rsrc  = rsrc;
    e.rd    = rd;
    e.alu   = alu;
    e.rdata = exp_rdata;
    e.pc4   = pc + 32'd4;
    e.pct   = pc + 32'h80;
    sb.push_back(e);

    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rsrc;
    LoadControlM = lc; StoreControlM = sc; rdM = rd;
    ALUResultM = alu; WriteDataM = wd;
    PCPlus4M = pc + 32'd4; PCTargetM = pc + 32'h80;
    pc = pc + 32'd4;

    for (int k = 0; k <= waits; k++) begin
      DMemReady = (k == waits) || !is_mem;
      DMemRData = (k == waits) ? rdata : ~rdata;
      @(negedge CLK);
      checks++;
      if (DMemReq !== is_mem) begin
        errors++;
        $display("FAIL %s req cyc%0d: got %b exp %b", name, k, DMemReq, is_mem);
      end
      checks++;
      if (StallM !== (is_mem && (k < waits))) begin
        errors++;
        $display("FAIL %s stall cyc%0d: got %b exp %b", name, k, StallM, is_mem && (k < waits));
      end
      checks++;
      if (DMemWe !== mw || MisalignM !== 1'b0) begin
        errors++;
        $display("FAIL %s we/misalign cyc%0d: got %b/%b exp %b/0", name, k, DMemWe, MisalignM, mw);
      end
      if (is_mem && k == 0) begin
        checks++;
        if (DMemBE !== exp_be || DMemAddr !== {alu[31:2], 2'b00}) begin
          errors++;
          $display("FAIL %s be/addr: got %b/%h exp %b/%h", name, DMemBE, DMemAddr, exp_be, {alu[31:2], 2'b00});
        end
        if (mw) begin
          checks++;
          if (DMemWData !== exp_wdata) begin
            errors++;
            $display("FAIL %s wdata: got %h exp %h", name, DMemWData, exp_wdata);
          end
        end
      end
      @(posedge CLK); #1;
      if (k < waits) begin
        checks++;
        if (RegWriteW !== 1'b0 || rdW !== 5'd0 || ALUResultW !== last_w.alu) begin
          errors++;
          $display("FAIL %s bubble cyc%0d: got rw=%b rd=%0d alu=%h exp rw=0 rd=0 alu=%h",
                   name, k, RegWriteW, rdW, ALUResultW, last_w.alu);
        end
      end
    end

    e = sb.pop_front();
    checks++;
    if (RegWriteW !== e.rw || rdW !== e.rd || ResultSrcW !== e.rsrc) begin
      errors++;
      $display("FAIL %s w_ctrl: got rw=%b rd=%0d src=%b exp rw=%b rd=%0d src=%b",
               name, RegWriteW, rdW, ResultSrcW, e.rw, e.rd, e.rsrc);
    end
    checks++;
    if (ReadDataW !== e.rdata) begin
      errors++;
      $display("FAIL %s readdata: got %h exp %h", name, ReadDataW, e.rdata);
    end
    checks++;
    if (ALUResultW !== e.alu || PCPlus4W !== e.pc4 || PCTargetW !== e.pct) begin
      errors++;
      $display("FAIL %s w_data: got %h/%h/%h exp %h/%h/%h",
               name, ALUResultW, PCPlus4W, PCTargetW, e.alu, e.pc4, e.pct);
    end
    last_w = e;
  endtask

  task automatic test_reset();
    drive_nop();
    RST = 1'b1;
    // A misaligned load with ready high must not leak through reset.
    ResultSrcM = RS_LOAD; LoadControlM = LW; ALUResultM = 32'h101;
    RegWriteM = 1'b1; rdM = 5'd3; DMemReady = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (DMemReq !== 1'b0 || StallM !== 1'b0 || MisalignM !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: got req=%b stall=%b mis=%b exp 0/0/0", DMemReq, StallM, MisalignM);
    end
    @(posedge CLK); #1;
    checks++;
    if (RegWriteW !== 1'b0 || ResultSrcW !== 3'b000 || rdW !== 5'd0 ||
        ALUResultW !== 32'h0 || ReadDataW !== 32'h0 || PCPlus4W !== 32'h0 || PCTargetW !== 32'h0) begin
      errors++;
      $display("FAIL reset_w: got rw=%b src=%b rd=%0d alu=%h rd=%h pc4=%h pct=%h exp all 0",
               RegWriteW, ResultSrcW, rdW, ALUResultW, ReadDataW, PCPlus4W, PCTargetW);
    end
    RST = 1'b0;
    drive_nop();
    last_w = '{1'b0, 3'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
  endtask

  task automatic test_store();
    run_op("sw", 1'b0, 1'b1, RS_ALU, LW, SW, 5'd0, 32'h100, 32'hDEADBEEF,
           32'h0, 0, 32'h0, 4'b1111, 32'hDEADBEEF);
    run_op("sb", 1'b0, 1'b1, RS_ALU, LW, SB, 5'd0, 32'h103, 32'h000000A5,
           32'h0, 0, 32'h0, 4'b1000, 32'hA5A5A5A5);
  endtask

  task automatic test_load_wait();
    run_op("lb_wait2", 1'b1, 1'b0, RS_LOAD, LB, SW, 5'd10, 32'h102, 32'h0,
           32'h1280FF00, 2, 32'hFFFFFF80, 4'b0000, 32'h0);
  endtask

  task automatic test_load_ext();
    run_op("lhu", 1'b1, 1'b0, RS_LOAD, LHU, SW, 5'd11, 32'h102, 32'h0,
           32'h80010000, 0, 32'h00008001, 4'b0000, 32'h0);
    run_op("lh", 1'b1, 1'b0, RS_LOAD, LH, SW, 5'd12, 32'h102, 32'h0,
           32'h80010000, 0, 32'hFFFF8001, 4'b0000, 32'h0);
    run_op("lbu", 1'b1, 1'b0, RS_LOAD, LBU, SW, 5'd13, 32'h301, 32'h0,
           32'h0000F100, 0, 32'h000000F1, 4'b0000, 32'h0);
  endtask

  task automatic test_misalign();
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = RS_LOAD; LoadControlM = LW;
    rdM = 5'd5; ALUResultM = 32'h101; PCPlus4M = 32'h2004; PCTargetM = 32'h2080;
    DMemReady = 1'b1; DMemRData = 32'h12345678;
    @(negedge CLK);
    checks++;
    if (MisalignM !== 1'b1 || DMemReq !== 1'b0 || StallM !== 1'b0) begin
      errors++;
      $display("FAIL misalign_lw: got mis=%b req=%b stall=%b exp 1/0/0", MisalignM, DMemReq, StallM);
    end
    @(posedge CLK); #1;
    checks++;
    if (RegWriteW !== 1'b0 || rdW !== 5'd5 || ALUResultW !== 32'h101) begin
      errors++;
      $display("FAIL misalign_w: got rw=%b rd=%0d alu=%h exp rw=0 rd=5 alu=00000101", RegWriteW, rdW, ALUResultW);
    end
    // Misaligned halfword store: no request, no write strobe.
    RegWriteM = 1'b0; MemWriteM = 1'b1; ResultSrcM = RS_ALU; StoreControlM = SH;
    ALUResultM = 32'h105; WriteDataM = 32'h1234;
    @(negedge CLK);
    checks++;
    if (MisalignM !== 1'b1 || DMemReq !== 1'b0 || DMemWe !== 1'b0 || DMemBE !== 4'b0000) begin
      errors++;
      $display("FAIL misalign_sh: got mis=%b req=%b we=%b be=%b exp 1/0/0/0000", MisalignM, DMemReq, DMemWe, DMemBE);
    end
    @(posedge CLK); #1;
    last_w.alu = 32'h105;
    drive_nop();
  endtask

  task automatic test_nonmem();
    run_op("alu_op", 1'b1, 1'b0, RS_ALU, LW, SW, 5'd7, 32'h12345678, 32'hFFFFFFFF,
           32'hCAFEF00D, 0, 32'h0, 4'b0000, 32'h0);
    run_op("jal_op", 1'b1, 1'b0, 3'b010, LW, SW, 5'd1, 32'h00000103, 32'h0,
           32'h0, 0, 32'h0, 4'b0000, 32'h0);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_lw", 1'b1, 1'b0, RS_LOAD, LW, SW, 5'd20, 32'h200, 32'h0,
           32'h11223344, 0, 32'h11223344, 4'b0000, 32'h0);
    run_op("b2b_lbu", 1'b1, 1'b0, RS_LOAD, LBU, SW, 5'd21, 32'h201, 32'h0,
           32'h11223344, 0, 32'h00000033, 4'b0000, 32'h0);
    run_op("b2b_lh", 1'b1, 1'b0, RS_LOAD, LH, SW, 5'd22, 32'h202, 32'h0,
           32'h11223344, 1, 32'h00001122, 4'b0000, 32'h0);
    run_op("b2b_sh", 1'b0, 1'b1, RS_ALU, LW, SH, 5'd0, 32'h102, 32'h0000BEEF,
           32'h0, 1, 32'h0, 4'b1100, 32'hBEEFBEEF);
  endtask

  task automatic test_reset_in_wait();
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = RS_LOAD; LoadControlM = LW;
    rdM = 5'd9; ALUResultM = 32'h400; PCPlus4M = 32'h3004; PCTargetM = 32'h3080;
    DMemReady = 1'b0; DMemRData = 32'h55AA55AA;
    @(negedge CLK);
    checks++;
    if (DMemReq !== 1'b1 || StallM !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_pre: got req=%b stall=%b exp 1/1", DMemReq, StallM);
    end
    @(posedge CLK); #1;   // now in WAIT
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (DMemReq !== 1'b0 || StallM !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_comb: got req=%b stall=%b exp 0/0", DMemReq, StallM);
    end
    @(posedge CLK); #1;
    checks++;
    if (RegWriteW !== 1'b0 || rdW !== 5'd0 || ALUResultW !== 32'h0 || ReadDataW !== 32'h0 ||
        PCPlus4W !== 32'h0 || PCTargetW !== 32'h0 || ResultSrcW !== 3'b000) begin
      errors++;
      $display("FAIL rst_wait_w: got rw=%b rd=%0d alu=%h rdat=%h pc4=%h pct=%h exp all 0",
               RegWriteW, rdW, ALUResultW, ReadDataW, PCPlus4W, PCTargetW);
    end
    RST = 1'b0;
    drive_nop();
    last_w = '{1'b0, 3'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
    // FSM must be back in IDLE: a non-memory cycle raises no request.
    @(negedge CLK);
    checks++;
    if (DMemReq !== 1'b0 || StallM !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_idle: got req=%b stall=%b exp 0/0", DMemReq, StallM);
    end
    @(posedge CLK); #1;
    run_op("post_rst_lw", 1'b1, 1'b0, RS_LOAD, LW, SW, 5'd15, 32'h404, 32'h0,
           32'h0BADF00D, 1, 32'h0BADF00D, 4'b0000, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    @(posedge CLK); #1;
    test_store();
    test_load_wait();
    test_load_ext();
    test_misalign();
    test_nonmem();
    test_back_to_back();
    test_reset_in_wait();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left exp 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
